// File: rtl/axi_lite_mem_arbiter.sv
// Shares one AXI4-Lite master port between the data (MEM) and fetch requesters, one transaction at a time.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration (default: data port has fixed priority).
module axi_lite_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_done,
  output logic                    d_err,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_done,
  output logic                    i_err,
  output logic                    mem_stall,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

  state_t                  state_reg;
  logic                    grant_i_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [DATA_WIDTH/8-1:0] wstrb_reg;
  logic                    awvalid_reg, wvalid_reg, bready_reg, arvalid_reg, rready_reg;
  logic                    d_done_reg, i_done_reg, d_err_reg, i_err_reg;
  logic [DATA_WIDTH-1:0]   d_rdata_reg, i_rdata_reg;
  logic                    grant_i_next;
  logic                    grant_fire;

  assign grant_fire = (state_reg == IDLE) && (d_req || i_req);

`ifdef ARB_ROUND_ROBIN_EN
  // rr_ptr_reg = 1 means fetch is favoured on the next contested grant.
  logic rr_ptr_reg;

  assign grant_i_next = i_req & (~d_req | rr_ptr_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= 1'b0;
    end else if (grant_fire) begin
      rr_ptr_reg <= ~grant_i_next;
    end
  end
`else
  assign grant_i_next = i_req & ~d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      grant_i_reg <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
      d_done_reg  <= 1'b0;
      i_done_reg  <= 1'b0;
      d_err_reg   <= 1'b0;
      i_err_reg   <= 1'b0;
      d_rdata_reg <= '0;
      i_rdata_reg <= '0;
    end else begin
      d_done_reg <= 1'b0;
      i_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_fire) begin
            grant_i_reg <= grant_i_next;
            addr_reg    <= grant_i_next ? i_addr : d_addr;
            if (!grant_i_next && d_we) begin
              wdata_reg   <= d_wdata;
              wstrb_reg   <= d_wstrb;
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              state_reg   <= WR_REQ;
            end else begin
              arvalid_reg <= 1'b1;
              state_reg   <= RD_ADDR;
            end
          end
        end
        WR_REQ: begin
          // AW and W handshake independently; move on once both have been accepted.
          if (awvalid_reg && m_awready) awvalid_reg <= 1'b0;
          if (wvalid_reg && m_wready) wvalid_reg <= 1'b0;
          if ((!awvalid_reg || m_awready) && (!wvalid_reg || m_wready)) begin
            bready_reg <= 1'b1;
            state_reg  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_bvalid) begin
            bready_reg <= 1'b0;
            d_done_reg <= ~grant_i_reg;
            i_done_reg <= grant_i_reg;
            if (grant_i_reg) i_err_reg <= (m_bresp != 2'b00);
            else             d_err_reg <= (m_bresp != 2'b00);
            state_reg  <= DONE;
          end
        end
        RD_ADDR: begin
          if (m_arready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_rvalid) begin
            rready_reg <= 1'b0;
            d_done_reg <= ~grant_i_reg;
            i_done_reg <= grant_i_reg;
            if (grant_i_reg) begin
              i_rdata_reg <= m_rdata;
              i_err_reg   <= (m_rresp != 2'b00);
            end else begin
              d_rdata_reg <= m_rdata;
              d_err_reg   <= (m_rresp != 2'b00);
            end
            state_reg <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m_awaddr  = addr_reg;
  assign m_araddr  = addr_reg;
  assign m_wdata   = wdata_reg;
  assign m_wstrb   = wstrb_reg;
  assign m_awvalid = awvalid_reg;
  assign m_wvalid  = wvalid_reg;
  assign m_bready  = bready_reg;
  assign m_arvalid = arvalid_reg;
  assign m_rready  = rready_reg;
  assign d_done    = d_done_reg;
  assign i_done    = i_done_reg;
  assign d_err     = d_err_reg;
  assign i_err     = i_err_reg;
  assign d_rdata   = d_rdata_reg;
  assign i_rdata   = i_rdata_reg;
  assign mem_stall = d_req & ~d_done_reg;

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Directed bench for axi_lite_mem_arbiter: the bench plays the AXI slave and both requesters cycle by cycle.
module tb_axi_lite_mem_arbiter;

  logic        clk, rst_n;
  logic        d_req, d_we, d_done, d_err, i_req, i_done, i_err, mem_stall;
  logic [31:0] d_addr, d_wdata, d_rdata, i_addr, i_rdata;
  logic [3:0]  d_wstrb, m_wstrb;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]  m_bresp, m_rresp;

  int n_cmp = 0;
  int n_err = 0;
  int d_done_cnt = 0;
  int ar_cnt = 0;
  int cnt0, ar0;
  logic [31:0] seen;
  logic [3:0]  exp_seq;

  axi_lite_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
    .mem_stall(mem_stall),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    d_done_cnt <= d_done_cnt + int'(d_done);
    ar_cnt     <= ar_cnt + int'(m_arvalid);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Zero-wait read response; caller raises m_arready before calling. Returns in the DONE cycle.
  task automatic slave_rd(input logic [31:0] data, input logic [1:0] resp, output logic [31:0] addr_seen);
    @(negedge clk);
    addr_seen = m_araddr;
    @(negedge clk);
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rdata   = data;
    m_rresp   = resp;
    @(negedge clk);
    m_rvalid = 1'b0;
    m_rresp  = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    i_req = 1'b0; i_addr = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    exp_seq = 4'b0000;
    repeat (2) @(negedge clk);

    // reset state
    chk1("rst_arvalid", m_arvalid, 1'b0);
    chk1("rst_awvalid", m_awvalid, 1'b0);
    chk1("rst_wvalid", m_wvalid, 1'b0);
    chk1("rst_bready", m_bready, 1'b0);
    chk1("rst_rready", m_rready, 1'b0);
    chk1("rst_d_done", d_done, 1'b0);
    chk1("rst_i_done", i_done, 1'b0);
    chk("rst_araddr", m_araddr, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // single zero-wait read
    d_req = 1'b1; d_addr = 32'h1000; m_arready = 1'b1;
    #1 chk1("rd_stall_req", mem_stall, 1'b1);
    @(negedge clk);
    chk1("rd_c1_arvalid", m_arvalid, 1'b1);
    chk("rd_c1_araddr", m_araddr, 32'h1000);
    @(negedge clk);
    chk1("rd_c2_arvalid", m_arvalid, 1'b0);
    chk1("rd_c2_rready", m_rready, 1'b1);
    chk1("rd_c2_stall", mem_stall, 1'b1);
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF; m_rresp = 2'b00;
    @(negedge clk);
    chk1("rd_c3_done", d_done, 1'b1);
    chk("rd_c3_rdata", d_rdata, 32'hDEADBEEF);
    chk1("rd_c3_err", d_err, 1'b0);
    chk1("rd_c3_stall", mem_stall, 1'b0);
    chk1("rd_c3_rready", m_rready, 1'b0);
    m_rvalid = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk1("rd_c4_done", d_done, 1'b0);
    chk("rd_c4_rdata_hold", d_rdata, 32'hDEADBEEF);

    // write, W accepted at once, AW held off for three cycles
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h12345678; d_wstrb = 4'h3;
    m_awready = 1'b0; m_wready = 1'b1;
    cnt0 = d_done_cnt;
    @(negedge clk);
    chk1("wr_c1_awvalid", m_awvalid, 1'b1);
    chk1("wr_c1_wvalid", m_wvalid, 1'b1);
    chk("wr_c1_awaddr", m_awaddr, 32'h2000);
    chk("wr_c1_wdata", m_wdata, 32'h12345678);
    chk("wr_c1_wstrb", {28'h0, m_wstrb}, 32'h3);
    @(negedge clk);
    chk1("wr_c2_wvalid", m_wvalid, 1'b0);
    chk1("wr_c2_awvalid", m_awvalid, 1'b1);
    m_wready = 1'b0;
    @(negedge clk);
    chk1("wr_c3_awvalid", m_awvalid, 1'b1);
    @(negedge clk);
    chk1("wr_c4_awvalid", m_awvalid, 1'b1);
    chk1("wr_c4_bready", m_bready, 1'b0);
    chk("wr_c4_awaddr", m_awaddr, 32'h2000);
    m_awready = 1'b1;
    @(negedge clk);
    chk1("wr_c5_awvalid", m_awvalid, 1'b0);
    chk1("wr_c5_bready", m_bready, 1'b1);
    chk1("wr_c5_done", d_done, 1'b0);
    m_awready = 1'b0; m_bvalid = 1'b1; m_bresp = 2'b00;
    @(negedge clk);
    chk1("wr_c6_done", d_done, 1'b1);
    chk1("wr_c6_err", d_err, 1'b0);
    chk1("wr_c6_bready", m_bready, 1'b0);
    m_bvalid = 1'b0; d_req = 1'b0; d_we = 1'b0;
    repeat (3) @(negedge clk);
    chk("wr_done_count", d_done_cnt - cnt0, 32'd1);

    // fetch with SLVERR, then fetch with OKAY
    i_req = 1'b1; i_addr = 32'h0; m_arready = 1'b1;
    slave_rd(32'hBAD0BAD0, 2'b10, seen);
    chk("ferr_araddr", seen, 32'h0);
    chk1("ferr_i_done", i_done, 1'b1);
    chk1("ferr_i_err", i_err, 1'b1);
    chk1("ferr_d_done", d_done, 1'b0);
    chk("ferr_i_rdata", i_rdata, 32'hBAD0BAD0);
    i_req = 1'b0;
    @(negedge clk);
    chk1("ferr_done_drop", i_done, 1'b0);
    i_req = 1'b1; i_addr = 32'h4; m_arready = 1'b1;
    slave_rd(32'h00000013, 2'b00, seen);
    chk("fok_araddr", seen, 32'h4);
    chk1("fok_i_done", i_done, 1'b1);
    chk1("fok_i_err", i_err, 1'b0);
    chk("fok_i_rdata", i_rdata, 32'h00000013);
    i_req = 1'b0;
    @(negedge clk);

    // both ports requesting for four transactions (bit k = 1 means fetch wins)
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b0000;
`endif
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; i_req = 1'b1; i_addr = 32'h4000;
    for (int k = 0; k < 4; k++) begin
      m_arready = 1'b1;
      slave_rd(32'hA0 + 32'(k), 2'b00, seen);
      chk($sformatf("arb%0d_addr", k), seen, exp_seq[k] ? 32'h4000 : 32'h3000);
      chk1($sformatf("arb%0d_i_done", k), i_done, exp_seq[k]);
      chk1($sformatf("arb%0d_d_done", k), d_done, ~exp_seq[k]);
      if (k == 3) begin
        d_req = 1'b0; i_req = 1'b0;
      end
      @(negedge clk);
    end

    // data request dropped while in RD_DATA
    d_req = 1'b1; d_addr = 32'h5000; m_arready = 1'b1;
    @(negedge clk);
    chk1("drop_c1_arvalid", m_arvalid, 1'b1);
    @(negedge clk);
    chk1("drop_c2_rready", m_rready, 1'b1);
    cnt0 = d_done_cnt; ar0 = ar_cnt;
    d_req = 1'b0; m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D; m_rresp = 2'b00;
    @(negedge clk);
    chk1("drop_c3_done", d_done, 1'b1);
    chk("drop_c3_rdata", d_rdata, 32'hCAFEF00D);
    m_rvalid = 1'b0;
    repeat (4) @(negedge clk);
    chk("drop_done_count", d_done_cnt - cnt0, 32'd1);
    chk("drop_no_new_ar", ar_cnt - ar0, 32'd0);

    // asynchronous reset while AR is stalled
    d_req = 1'b1; d_addr = 32'h6000; m_arready = 1'b0;
    @(negedge clk);
    chk1("arst_c1_arvalid", m_arvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("arst_arvalid", m_arvalid, 1'b0);
    chk1("arst_rready", m_rready, 1'b0);
    chk("arst_araddr", m_araddr, 32'h0);
    chk("arst_d_rdata", d_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; m_arready = 1'b1;
    slave_rd(32'h600D600D, 2'b00, seen);
    chk("arst_rd_addr", seen, 32'h6000);
    chk1("arst_rd_done", d_done, 1'b1);
    chk("arst_rd_rdata", d_rdata, 32'h600D600D);
    chk1("arst_rd_err", d_err, 1'b0);
    d_req = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_mem_arbiter.md
# axi_lite_mem_arbiter

Sequences and shares the core's single AXI4-Lite master port between the data-memory requester (MEM stage) and the instruction-fetch requester. It runs one transaction at a time and returns read data, completion and error status to the winning requester. It also drives `mem_stall`, which feeds the hazard unit's `mem_read_write` input and freezes the pipeline while a data access is outstanding.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, data width; `DATA_WIDTH/8` strobe bits

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `d_req`  in  1  data request; held until `d_done`
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_WIDTH  data address
- `d_wdata`  in  DATA_WIDTH  write data
- `d_wstrb`  in  DATA_WIDTH/8  byte strobes
- `d_rdata`  out  DATA_WIDTH  read data, valid while `d_done`=1
- `d_done`  out  1  one-cycle completion pulse
- `d_err`  out  1  response was not OKAY; valid with `d_done`
- `i_req`  in  1  fetch request (read only); held until `i_done`
- `i_addr`  in  ADDR_WIDTH  fetch address
- `i_rdata`  out  DATA_WIDTH  instruction, valid while `i_done`=1
- `i_done`, `i_err`  out  1  as for the data port
- `mem_stall`  out  1  `d_req & ~d_done`, combinational
- `m_awaddr`/`m_awvalid`/`m_awready`, `m_wdata`/`m_wstrb`/`m_wvalid`/`m_wready`, `m_bresp[1:0]`/`m_bvalid`/`m_bready`, `m_araddr`/`m_arvalid`/`m_arready`, `m_rdata`/`m_rresp[1:0]`/`m_rvalid`/`m_rready`: standard AXI4-Lite master channels, widths per parameters

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: arbitrate among active requests (see Configuration). On the winning edge:
  - register addr, wdata, wstrb, we and grant id;
  - a write goes to WR_REQ with `m_awvalid`=`m_wvalid`=1;
  - a read goes to RD_ADDR with `m_arvalid`=1.
- WR_REQ: AW and W complete independently. Each valid drops on its own handshake. When both are done, go to WR_RESP with `m_bready`=1. AW and W completing in the same cycle is legal.
- WR_RESP: on `m_bvalid`, capture `bresp!=0` as err, drop `m_bready`, go to DONE.
- RD_ADDR: on `m_arready`, drop `m_arvalid`, raise `m_rready`, go to RD_DATA.
- RD_DATA: on `m_rvalid`, capture `m_rdata` and `rresp!=0`, drop `m_rready`, go to DONE.
- DONE: pulse the granted port's `done` for one cycle with its rdata/err, then return to IDLE. The next arbitration happens in IDLE on the following edge.
- `d_rdata`/`i_rdata` hold their last captured value. `err` outputs are only meaningful with `done`.
- A request dropped mid-transaction does not abort it. The transaction completes and `done` still pulses.
- Requests are never reordered. Only one transaction is outstanding.
- AXI valid and ready outputs are registered and never depend combinationally on AXI inputs.
- Address, data and strobe outputs stay stable while the corresponding valid is high.

## Timing
- Reset values:
  - state IDLE;
  - all `m_*valid`, `m_*ready`, `d_done`, `i_done`, `d_err`, `i_err` = 0;
  - addresses, data, strobes and rdata = 0;
  - round-robin pointer = data port.
- Reset mid-transaction drops all valid and ready outputs asynchronously and abandons the transfer; the slave is reset together with the core.
- Read with zero-wait slave:
  - `d_req` sampled at edge 0;
  - `m_arvalid` cycle 1;
  - `m_rvalid` cycle 2;
  - `d_done` cycle 3.
- Write with zero-wait slave: `m_awvalid`/`m_wvalid` cycle 1, `m_bvalid` cycle 2, `d_done` cycle 3.
- Back-to-back: a request still held at the DONE cycle is arbitrated at the next IDLE edge. Minimum 4-cycle spacing per transaction.
- `mem_stall` falls in the same cycle `d_done` rises.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - when both ports request in IDLE, grant the port not granted last;
  - the pointer updates on every grant.
- Undefined: fixed priority, with the data port always winning over fetch; no pointer register.

## Test plan
- Single read, zero-wait slave: `d_req`=1, `d_addr`=0x1000, `m_rdata`=0xDEADBEEF -> `m_araddr`=0x1000 in cycle 1, `d_done`=1 in cycle 3, `d_rdata`=0xDEADBEEF, `d_err`=0, `mem_stall` 1→0 with `d_done`.
- Write with W-before-AW skew: `d_we`=1, `d_wdata`=0x12345678, `d_wstrb`=0x3; hold `m_awready`=0 for 3 cycles and `m_wready`=1 immediately -> `m_wvalid` drops after cycle 1, `m_awvalid` held 4 cycles, exactly one `d_done`.
- Error response: fetch read at 0x0 with `m_rresp`=2'b10 -> `i_done`=1, `i_err`=1; the next fetch with OKAY gives `i_err`=0.
- Simultaneous requests, `ARB_ROUND_ROBIN_EN` defined and both held for 4 transactions -> grants alternate D, I, D, I. Undefined -> D, D, D, D while `d_req` is held.
- `d_req` dropped in RD_DATA -> transaction completes, `d_done` pulses once, no new AR issued.
- Reset asserted while `m_arvalid`=1 and `m_arready`=0 -> `m_arvalid`=0 without waiting for a clock edge. After release, a fresh read completes normally.
